// File: rtl/hdp_spi_pkg.sv
// Shared constants and FSM state type for the HDP-1280-2 SPI register-access responder.
package hdp_spi_pkg;

  localparam int SPI_FRAME_BITS = 16;
  localparam int SPI_BYTE_BITS  = 8;
  localparam int SPI_RW_BIT     = 7;
  localparam int SPI_CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } spi_state_e;

endpackage

// File: rtl/hdp_spi_in_sync.sv
// Two-flop synchroniser for SCLK/CS/MOSI with rise/fall detection on SCLK and CS.
// MOSI leaves the same pipeline stage as SCLK so sampled bits stay aligned with their edges.
module hdp_spi_in_sync (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic cs_sync,
  output logic mosi_sync,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall
);

  localparam int         LANES    = 3;
  // Lane order {mosi, cs, sclk}; CS idles high so its lane resets to 1.
  localparam logic [2:0] LANE_RST = 3'b010;

  logic [LANES-1:0] raw;
  logic [LANES-1:0] meta_reg;
  logic [LANES-1:0] sync_reg;
  logic             sclk_prev_reg;
  logic             cs_prev_reg;

  assign raw = {mosi, cs, sclk};

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
          meta_reg[gi] <= LANE_RST[gi];
          sync_reg[gi] <= LANE_RST[gi];
        end else begin
          meta_reg[gi] <= raw[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b1;
    end else begin
      sclk_prev_reg <= sync_reg[0];
      cs_prev_reg   <= sync_reg[1];
    end
  end

  assign cs_sync   = sync_reg[1];
  assign mosi_sync = sync_reg[2];
  assign sclk_rise =  sync_reg[0] & ~sclk_prev_reg;
  assign sclk_fall = ~sync_reg[0] &  sclk_prev_reg;
  assign cs_rise   =  sync_reg[1] & ~cs_prev_reg;
  assign cs_fall   = ~sync_reg[1] &  cs_prev_reg;

endmodule

// File: rtl/hdp_spi_slave.sv
// SPI mode-0 responder for 16-bit {R/nW, addr[6:0], data[7:0]} frames onto a local register file.
// Define HDP_SPI_SLAVE_ABORT_CNT_EN to build the saturating aborted-frame counter.
module hdp_spi_slave
  import hdp_spi_pkg::*;
#(
  parameter int         NUM_REGS     = 16,
  parameter logic [7:0] IDLE_TX_BYTE = 8'h00
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_sclk,
  input  logic                  i_cs,
  input  logic                  i_mosi,
  output logic                  o_miso,
  output logic                  o_miso_oe,
  output logic [NUM_REGS*8-1:0] o_regs,
  output logic                  o_wr_strobe,
  output logic [6:0]            o_wr_addr,
  output logic [7:0]            o_wr_data,
  output logic                  o_rd_strobe,
  output logic                  o_busy,
  output logic [7:0]            o_abort_count
);

  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

  logic cs_sync, mosi_sync, sclk_rise, sclk_fall, cs_rise, cs_fall;

  hdp_spi_in_sync u_in_sync (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .sclk      (i_sclk),
    .cs        (i_cs),
    .mosi      (i_mosi),
    .cs_sync   (cs_sync),
    .mosi_sync (mosi_sync),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall)
  );

  spi_state_e           state_reg, state_next;
  logic [SPI_CNT_W-1:0] bit_cnt_reg;
  logic [6:0]           rx_shift_reg;
  logic [7:0]           tx_shift_reg;
  logic                 rw_reg;
  logic [6:0]           addr_reg;
  logic                 addr_valid_reg;
  logic [7:0]           regs_reg [NUM_REGS];
  logic                 wr_commit_reg;
  logic                 wr_strobe_reg;
  logic                 rd_strobe_reg;
  logic [6:0]           wr_addr_reg;
  logic [7:0]           wr_data_reg;

  logic       start_frame, frame_end, rx_shift_en, tx_shift_en, addr_latch, data_commit;
  logic       wr_en;
  logic [7:0] rx_byte;
  logic [7:0] rd_data;
`ifdef HDP_SPI_SLAVE_ABORT_CNT_EN
  logic       abort;
  logic [7:0] abort_cnt_reg;
`endif

  // Completed byte including the bit arriving on the current rise.
  assign rx_byte = {rx_shift_reg, mosi_sync};

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  // A CS rise takes priority over any coincident SCLK edge, which is discarded.
  always_comb begin
    state_next  = state_reg;
    start_frame = 1'b0;
    rx_shift_en = 1'b0;
    tx_shift_en = 1'b0;
    addr_latch  = 1'b0;
    data_commit = 1'b0;
`ifdef HDP_SPI_SLAVE_ABORT_CNT_EN
    abort       = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          start_frame = 1'b1;
          state_next  = ADDR;
        end
      end
      ADDR: begin
        if (cs_rise) begin
`ifdef HDP_SPI_SLAVE_ABORT_CNT_EN
          abort      = 1'b1;
`endif
          state_next = IDLE;
        end else begin
          if (sclk_rise) begin
            rx_shift_en = 1'b1;
            if (bit_cnt_reg == SPI_CNT_W'(SPI_BYTE_BITS - 1)) begin
              addr_latch = 1'b1;
              state_next = DATA;
            end
          end
          if (sclk_fall && bit_cnt_reg != '0) tx_shift_en = 1'b1;
        end
      end
      DATA: begin
        if (cs_rise) begin
`ifdef HDP_SPI_SLAVE_ABORT_CNT_EN
          abort      = 1'b1;
`endif
          state_next = IDLE;
        end else begin
          if (sclk_rise) begin
            rx_shift_en = 1'b1;
            if (bit_cnt_reg == SPI_CNT_W'(SPI_FRAME_BITS - 1)) begin
              data_commit = 1'b1;
              state_next  = DONE;
            end
          end
          // The fall right after bit 8 must keep the freshly loaded read MSB on MISO.
          if (sclk_fall && bit_cnt_reg > SPI_CNT_W'(SPI_BYTE_BITS)) tx_shift_en = 1'b1;
        end
      end
      DONE: begin
        if (cs_rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign frame_end = (state_reg != IDLE) && (state_next == IDLE);
  assign wr_en     = data_commit & ~rw_reg & addr_valid_reg;

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rx_byte[6:0] == 7'(i)) rd_data = regs_reg[i];
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bit_cnt_reg    <= '0;
      rx_shift_reg   <= '0;
      tx_shift_reg   <= 8'h00;
      rw_reg         <= 1'b0;
      addr_reg       <= '0;
      addr_valid_reg <= 1'b0;
    end else if (start_frame || frame_end) begin
      bit_cnt_reg  <= '0;
      tx_shift_reg <= IDLE_TX_BYTE;
    end else begin
      if (rx_shift_en) begin
        rx_shift_reg <= rx_byte[6:0];
        bit_cnt_reg  <= bit_cnt_reg + SPI_CNT_W'(1);
      end
      if (addr_latch) begin
        rw_reg         <= rx_byte[SPI_RW_BIT];
        addr_reg       <= rx_byte[6:0];
        addr_valid_reg <= {1'b0, rx_byte[6:0]} < NUM_REGS_W;
        tx_shift_reg   <= rx_byte[SPI_RW_BIT] ? rd_data : 8'h00;
      end else if (tx_shift_en) begin
        tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= 8'h00;
      wr_commit_reg <= 1'b0;
      wr_strobe_reg <= 1'b0;
      rd_strobe_reg <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && addr_reg == 7'(i)) regs_reg[i] <= rx_byte;
      end
      if (wr_en) begin
        wr_addr_reg <= addr_reg;
        wr_data_reg <= rx_byte;
      end
      // Strobe trails the register update by one cycle.
      wr_commit_reg <= wr_en;
      wr_strobe_reg <= wr_commit_reg;
      rd_strobe_reg <= addr_latch & rx_byte[SPI_RW_BIT];
    end
  end

`ifdef HDP_SPI_SLAVE_ABORT_CNT_EN
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)                          abort_cnt_reg <= 8'h00;
    else if (abort && abort_cnt_reg != 8'hFF) abort_cnt_reg <= abort_cnt_reg + 8'd1;
  end
  assign o_abort_count = abort_cnt_reg;
`else
  assign o_abort_count = 8'h00;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
      assign o_regs[gi*8 +: 8] = regs_reg[gi];
    end
  endgenerate

  assign o_miso_oe   = ~cs_sync;
  assign o_miso      = o_miso_oe & tx_shift_reg[7];
  assign o_wr_strobe = wr_strobe_reg;
  assign o_wr_addr   = wr_addr_reg;
  assign o_wr_data   = wr_data_reg;
  assign o_rd_strobe = rd_strobe_reg;
  assign o_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_hdp_spi_slave.sv
// Bench for hdp_spi_slave: directed frames plus random frames against a frame-level register model.
module tb_hdp_spi_slave;

  localparam int         NREGS     = 16;
  localparam logic [7:0] IDLE_BYTE = 8'h00;

  logic               i_clock = 1'b0;
  logic               i_reset_n;
  logic               i_sclk;
  logic               i_cs;
  logic               i_mosi;
  logic               o_miso;
  logic               o_miso_oe;
  logic [NREGS*8-1:0] o_regs;
  logic               o_wr_strobe;
  logic [6:0]         o_wr_addr;
  logic [7:0]         o_wr_data;
  logic               o_rd_strobe;
  logic               o_busy;
  logic [7:0]         o_abort_count;

  hdp_spi_slave #(.NUM_REGS(NREGS), .IDLE_TX_BYTE(IDLE_BYTE)) dut (
    .i_clock       (i_clock),
    .i_reset_n     (i_reset_n),
    .i_sclk        (i_sclk),
    .i_cs          (i_cs),
    .i_mosi        (i_mosi),
    .o_miso        (o_miso),
    .o_miso_oe     (o_miso_oe),
    .o_regs        (o_regs),
    .o_wr_strobe   (o_wr_strobe),
    .o_wr_addr     (o_wr_addr),
    .o_wr_data     (o_wr_data),
    .o_rd_strobe   (o_rd_strobe),
    .o_busy        (o_busy),
    .o_abort_count (o_abort_count)
  );

  always #5 i_clock = ~i_clock;

  int     n_checks = 0;
  int     n_pass   = 0;
  longint cyc      = 0;
  int     wr_seen  = 0;
  int     rd_seen  = 0;
  longint last_wr_cyc = 0;

  // Reference model state
  logic [7:0] m_regs [NREGS];
  logic [6:0] m_wr_addr;
  logic [7:0] m_wr_data;
  int         m_wr_cnt;
  int         m_rd_cnt;
  int         m_abort;

  always @(posedge i_clock) cyc++;

  always @(negedge i_clock) begin
    if (o_wr_strobe) begin
      wr_seen++;
      last_wr_cyc = cyc;
    end
    if (o_rd_strobe) rd_seen++;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  function automatic logic [NREGS*8-1:0] model_flat();
    logic [NREGS*8-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i*8 +: 8] = m_regs[i];
    return v;
  endfunction

  function automatic int expected_abort();
`ifdef HDP_SPI_SLAVE_ABORT_CNT_EN
    return m_abort;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_wr_addr = '0;
    m_wr_data = 8'h00;
    m_abort   = 0;
  endtask

  // One master frame: CS low, nrise SCLK pulses carrying word MSB-first, CS high for gap cycles.
  task automatic run_frame(input logic [15:0] word, input int nrise, input int half, input int gap);
    logic        rw;
    logic [6:0]  a;
    logic [7:0]  d;
    bit          valid;
    logic [7:0]  rd_byte;
    logic [15:0] exp_miso;
    logic [15:0] got_miso;
    logic [15:0] mask;
    longint      rise16_cyc;
    bit          wrote;
    rw = word[15];
    a  = word[14:8];
    d  = word[7:0];
    valid    = (int'(a) < NREGS);
    rd_byte  = (rw && valid) ? m_regs[int'(a)] : 8'h00;
    exp_miso = {IDLE_BYTE, rd_byte};
    got_miso = '0;
    mask     = '0;
    rise16_cyc = 0;

    i_cs   = 1'b0;
    i_mosi = word[15];
    wait_cyc(half);
    for (int k = 0; k < nrise; k++) begin
      if (k < 16) begin
        got_miso[15-k] = o_miso;
        mask[15-k]     = 1'b1;
      end
      if (k == 0) check_eq("miso_oe", o_miso_oe, 1);
      i_sclk = 1'b1;
      if (k == 15) rise16_cyc = cyc;
      wait_cyc(half);
      i_sclk = 1'b0;
      if (k < 15) i_mosi = word[14-k];
      else        i_mosi = 1'($urandom_range(0, 1));
      wait_cyc(half);
    end
    i_cs = 1'b1;
    wait_cyc(gap);

    wrote = (nrise >= 16) && !rw && valid;
    if (nrise < 16 && m_abort < 255) m_abort++;
    if (nrise >= 8 && rw) m_rd_cnt++;
    if (wrote) begin
      m_regs[int'(a)] = d;
      m_wr_addr = a;
      m_wr_data = d;
      m_wr_cnt++;
    end

    $display("frame %04h rises=%0d half=%0d gap=%0d miso=%04h", word, nrise, half, gap, got_miso & mask);
    check_eq("miso_bits", got_miso & mask, exp_miso & mask);
    check_eq("regs", o_regs, model_flat());
    check_eq("wr_strobes", wr_seen, m_wr_cnt);
    check_eq("rd_strobes", rd_seen, m_rd_cnt);
    check_eq("wr_addr", o_wr_addr, m_wr_addr);
    check_eq("wr_data", o_wr_data, m_wr_data);
    check_eq("busy", o_busy, 0);
    check_eq("abort_count", o_abort_count, expected_abort());
    if (wrote) check_eq("wr_latency", last_wr_cyc - rise16_cyc, 4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_regs"}, o_regs, '0);
    check_eq({tag, "_busy"}, o_busy, 0);
    check_eq({tag, "_miso"}, o_miso, 0);
    check_eq({tag, "_miso_oe"}, o_miso_oe, 0);
    check_eq({tag, "_wr_strobe"}, o_wr_strobe, 0);
    check_eq({tag, "_rd_strobe"}, o_rd_strobe, 0);
    check_eq({tag, "_wr_addr"}, o_wr_addr, 0);
    check_eq({tag, "_wr_data"}, o_wr_data, 0);
    check_eq({tag, "_abort"}, o_abort_count, 0);
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] rst_word;
    int          nr;
    i_reset_n = 1'b0;
    i_cs      = 1'b1;
    i_sclk    = 1'b0;
    i_mosi    = 1'b0;
    m_wr_cnt  = 0;
    m_rd_cnt  = 0;
    model_reset();
    wait_cyc(3);
    check_reset_outputs("reset");
    i_reset_n = 1'b1;
    wait_cyc(3);

    run_frame(16'h053C, 16, 33, 3);
    run_frame(16'h8500, 16, 33, 4);
    run_frame(16'h7FAA, 16, 5, 3);
    run_frame(16'hFF00, 16, 5, 3);
    run_frame(16'h0211, 10, 6, 4);
    run_frame(16'h0211, 16, 6, 4);
    run_frame(16'h0001, 16, 4, 3);
    run_frame(16'h0102, 16, 4, 3);
    run_frame(16'h0304, 20, 4, 3);
    run_frame(16'h8300, 16, 4, 3);

    // Reset in the middle of the data byte of a write to reg4
    rst_word = 16'h0455;
    i_cs   = 1'b0;
    i_mosi = rst_word[15];
    wait_cyc(5);
    for (int k = 0; k < 11; k++) begin
      i_sclk = 1'b1;
      wait_cyc(5);
      i_sclk = 1'b0;
      i_mosi = rst_word[14-k];
      wait_cyc(5);
    end
    i_reset_n = 1'b0;
    wait_cyc(1);
    $display("mid-frame reset asserted");
    check_reset_outputs("midrst");
    i_cs   = 1'b1;
    i_sclk = 1'b0;
    wait_cyc(3);
    i_reset_n = 1'b1;
    model_reset();
    wait_cyc(3);
    check_eq("post_rst_busy", o_busy, 0);
    run_frame(16'h0455, 16, 5, 3);
    run_frame(16'h8400, 16, 5, 3);

    for (int n = 0; n < 40; n++) begin
      w[15]   = 1'($urandom_range(0, 1));
      w[14:8] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127))
                                            : 7'($urandom_range(0, NREGS + 3));
      w[7:0]  = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0, 1:    nr = $urandom_range(1, 15);
        2:       nr = $urandom_range(17, 20);
        default: nr = 16;
      endcase
      run_frame(w, nr, $urandom_range(4, 8), $urandom_range(3, 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
